sreg_piso_stream: RTL and testbench

SREG_PISO_STREAM -- requirements
Module: sreg_piso_stream

---
 rtl/sreg_pkg.sv | 14 +
 rtl/sreg_bit_counter.sv | 30 +++
 rtl/sreg_piso_stream.sv | 92 +++++++++
 tb/tb_sreg_piso_stream.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sreg_pkg.sv
// Shared definitions for the serialiser: FSM state type and counter sizing.
package sreg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sreg_state_e;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sreg_bit_counter.sv
// Bit-position counter for one serialised word; saturates at WIDTH-1.
module sreg_bit_counter
  import sreg_pkg::*;
#(
  parameter int WIDTH = 9,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= '0;
    else if (i_en && !o_tc)
      r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/sreg_piso_stream.sv
// Parallel-in serial-out streamer with valid/ready on both sides and
// zero-gap reload on the last-bit consume cycle.
module sreg_piso_stream
  import sreg_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_parallel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_serial,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  sreg_state_e      r_state;
  logic [WIDTH-1:0] r_sreg;
  logic             r_serial;

  logic [CW-1:0]    w_cnt;
  logic             w_tc;
  logic             w_accept;
  logic             w_adv;
  logic             w_load_bit;
  logic             w_shift_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_shift_rest;

  assign out_valid  = (r_state == ST_SHIFT);
  assign busy       = out_valid;
  assign out_serial = r_serial;
  assign out_first  = out_valid && (w_cnt == '0);
  assign out_last   = out_valid && w_tc;

  // Held low during reset so nothing is accepted while the block is cleared.
  assign in_ready = !rst && (!out_valid || (out_last && out_ready));
  assign w_accept = in_valid && in_ready;
  assign w_adv    = out_valid && out_ready;

  // r_serial holds the bit on the wire; r_sreg holds the bits still to come,
  // refilled with IDLE_LEVEL from the far end.
  if (MSB_FIRST) begin : g_msb
    assign w_load_bit   = in_parallel[WIDTH-1];
    assign w_load_rest  = {in_parallel[WIDTH-2:0], IDLE_LEVEL};
    assign w_shift_bit  = r_sreg[WIDTH-1];
    assign w_shift_rest = {r_sreg[WIDTH-2:0], IDLE_LEVEL};
  end else begin : g_lsb
    assign w_load_bit   = in_parallel[0];
    assign w_load_rest  = {IDLE_LEVEL, in_parallel[WIDTH-1:1]};
    assign w_shift_bit  = r_sreg[0];
    assign w_shift_rest = {IDLE_LEVEL, r_sreg[WIDTH-1:1]};
  end

  sreg_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept || (w_adv && w_tc)),
    .i_en   (w_adv),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sreg   <= '0;
      r_serial <= IDLE_LEVEL;
    end else if (w_accept) begin
      r_state  <= ST_SHIFT;
      r_sreg   <= w_load_rest;
      r_serial <= w_load_bit;
    end else if (w_adv) begin
      if (w_tc) begin
        r_state  <= ST_IDLE;
        r_serial <= IDLE_LEVEL;
      end else begin
        r_sreg   <= w_shift_rest;
        r_serial <= w_shift_bit;
      end
    end
  end

endmodule

// File: tb/tb_sreg_piso_stream.sv
// Directed checks of sreg_piso_stream: LSB/MSB order, back-to-back, stall, reset.
module tb_sreg_piso_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_parallel;
  logic       out_ready;

  logic rdy_l, vld_l, ser_l, fst_l, lst_l, bsy_l;
  logic rdy_m, vld_m, ser_m, fst_m, lst_m, bsy_m;
  logic rdy_h, vld_h, ser_h, fst_h, lst_h, bsy_h;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sreg_piso_stream #(.WIDTH(9), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l),
    .in_parallel(in_parallel), .out_ready(out_ready), .out_valid(vld_l),
    .out_serial(ser_l), .out_first(fst_l), .out_last(lst_l), .busy(bsy_l));

  sreg_piso_stream #(.WIDTH(9), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m),
    .in_parallel(in_parallel), .out_ready(out_ready), .out_valid(vld_m),
    .out_serial(ser_m), .out_first(fst_m), .out_last(lst_m), .busy(bsy_m));

  sreg_piso_stream #(.WIDTH(9), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_h),
    .in_parallel(in_parallel), .out_ready(out_ready), .out_valid(vld_h),
    .out_serial(ser_h), .out_first(fst_h), .out_last(lst_h), .busy(bsy_h));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " vld_l"}, vld_l, 1'b0);
    chk({tag, " bsy_l"}, bsy_l, 1'b0);
    chk({tag, " ser_l"}, ser_l, 1'b0);
    chk({tag, " ser_m"}, ser_m, 1'b0);
    chk({tag, " ser_h"}, ser_h, 1'b1);
    chk({tag, " vld_m"}, vld_m, 1'b0);
  endtask

  // Emission order reads left to right in sl/sm (sl[8] is the first bit out).
  // Entered and left 1ns after a rising edge with the DUTs idle.
  task automatic send_word(input logic [8:0] d, input logic [8:0] sl,
                           input logic [8:0] sm, input string tag);
    in_valid    = 1'b1;
    in_parallel = d;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_parallel = 9'h0AA;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("%s vld b%0d", tag, i), vld_l, 1'b1);
      chk($sformatf("%s ser_l b%0d", tag, i), ser_l, sl[8-i]);
      chk($sformatf("%s ser_m b%0d", tag, i), ser_m, sm[8-i]);
      chk($sformatf("%s ser_h b%0d", tag, i), ser_h, sl[8-i]);
      chk($sformatf("%s first b%0d", tag, i), fst_l, (i == 0));
      chk($sformatf("%s last b%0d", tag, i), lst_m, (i == 8));
      chk($sformatf("%s rdy b%0d", tag, i), rdy_l, (i == 8));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_idle({tag, " end"});
    chk({tag, " end rdy"}, rdy_l, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_parallel = 9'h000; out_ready = 1'b1;

    @(negedge clk);
    chk_idle("reset");
    chk("reset rdy", rdy_l, 1'b0);
    chk("reset first", fst_l, 1'b0);
    chk("reset last", lst_l, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset rdy", rdy_l, 1'b1);
    @(posedge clk); #1;

    // 1A5: LSB 1,0,1,0,0,1,0,1,1  MSB 1,1,0,1,0,0,1,0,1
    send_word(9'h1A5, 9'b101001011, 9'b110100101, "w1A5");

    // Back-to-back 1FF then 000 with in_valid held across the boundary
    in_valid = 1'b1; in_parallel = 9'h1FF;
    @(posedge clk); #1;
    in_parallel = 9'h000;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("b2b vld %0d", i), vld_l, 1'b1);
      chk($sformatf("b2b ser %0d", i), ser_l, (i < 9));
      chk($sformatf("b2b rdy %0d", i), rdy_l, (i == 8 || i == 17));
      chk($sformatf("b2b first %0d", i), fst_l, (i == 0 || i == 9));
      @(posedge clk); #1;
      if (i == 8) in_valid = 1'b0;
    end
    @(negedge clk);
    chk_idle("b2b end");
    @(posedge clk); #1;

    // Backpressure: bit 4 (index 3) held for 4 cycles
    in_valid = 1'b1; in_parallel = 9'h1A5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      for (int k = 0; k < ((j == 3) ? 4 : 1); k++) begin
        out_ready = (j != 3) || (k == 3);
        @(negedge clk);
        chk($sformatf("bp vld %0d.%0d", j, k), vld_l, 1'b1);
        chk($sformatf("bp ser %0d.%0d", j, k), ser_l, logic'((9'b101001011 >> (8 - j)) & 9'd1));
        chk($sformatf("bp last %0d.%0d", j, k), lst_l, (j == 8));
        chk($sformatf("bp rdy %0d.%0d", j, k), rdy_l, (j == 8));
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle("bp end");
    @(posedge clk); #1;

    // Reset mid-word during bit 5 (index 4)
    in_valid = 1'b1; in_parallel = 9'h1A5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid ser b4", ser_l, 1'b0);
    chk("mid ser_m b4", ser_m, 1'b0);
    chk("mid vld b4", vld_l, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_idle("rst async");
    chk("rst async rdy", rdy_l, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst rel rdy", rdy_l, 1'b1);
    chk_idle("rst rel");
    @(posedge clk); #1;

    // 0F3: LSB 1,1,0,0,1,1,1,1,0  MSB 0,1,1,1,1,0,0,1,1
    send_word(9'h0F3, 9'b110011110, 9'b011110011, "w0F3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
